// File: rtl/solver_scheduler.sv
// Round-robin front end for a shared Solver core: grants one of enc/dec/pw jobs,
// latches operands, drives the work code for the job's latency and returns the result.
module solver_scheduler #(
  parameter int unsigned LAT_ENC = 3,
  parameter int unsigned LAT_DEC = 3,
  parameter int unsigned LAT_PW  = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        enc_req,
  input  logic [59:0] enc_data,
  output logic        enc_gnt,
  input  logic        dec_req,
  input  logic [77:0] dec_data,
  output logic        dec_gnt,
  input  logic        pw_req,
  output logic        pw_gnt,
  output logic [59:0] slv_data_1,
  output logic [77:0] slv_data_2,
  output logic [1:0]  slv_work,
  input  logic [77:0] slv_out_1,
  input  logic [59:0] slv_out_2,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic [77:0] rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {
    JOB_ENC  = 2'b00,
    JOB_DEC  = 2'b01,
    JOB_PW   = 2'b10,
    JOB_HOLD = 2'b11
  } job_t;

  state_t     state_q, state_next;
  job_t       last_q, job_q, pick;
  logic       grant;
  logic [3:0] cnt_q, lat_sel;

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_next;
  end

  // Grant is decided combinationally so the pulse lands in the same cycle the
  // request is seen; DONE accepts a new job exactly like IDLE.
  always_comb begin
    pick       = JOB_ENC;
    grant      = 1'b0;
    state_next = state_q;
    enc_gnt    = 1'b0;
    dec_gnt    = 1'b0;
    pw_gnt     = 1'b0;

    case (last_q)
      JOB_ENC: begin
        if      (dec_req) pick = JOB_DEC;
        else if (pw_req)  pick = JOB_PW;
        else              pick = JOB_ENC;
      end
      JOB_DEC: begin
        if      (pw_req)  pick = JOB_PW;
        else if (enc_req) pick = JOB_ENC;
        else              pick = JOB_DEC;
      end
      default: begin
        if      (enc_req) pick = JOB_ENC;
        else if (dec_req) pick = JOB_DEC;
        else              pick = JOB_PW;
      end
    endcase

    case (state_q)
      IDLE, DONE: begin
        grant      = !Rst && (enc_req || dec_req || pw_req);
        state_next = grant ? ISSUE : IDLE;
      end
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt_q == 4'd1) state_next = DONE;
      default: state_next = IDLE;
    endcase

    enc_gnt = grant && (pick == JOB_ENC);
    dec_gnt = grant && (pick == JOB_DEC);
    pw_gnt  = grant && (pick == JOB_PW);
  end

  always_comb begin
    case (job_q)
      JOB_ENC: lat_sel = 4'(LAT_ENC);
      JOB_DEC: lat_sel = 4'(LAT_DEC);
      default: lat_sel = 4'(LAT_PW);
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      last_q     <= JOB_PW;
      job_q      <= JOB_ENC;
      cnt_q      <= '0;
      slv_data_1 <= '0;
      slv_data_2 <= '0;
      slv_work   <= JOB_HOLD;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      busy       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (grant) begin
        last_q   <= pick;
        job_q    <= pick;
        slv_work <= pick;
        busy     <= 1'b1;
        if (pick == JOB_ENC) slv_data_1 <= enc_data;
        if (pick == JOB_DEC) slv_data_2 <= dec_data;
      end
      if (state_q == ISSUE) cnt_q <= lat_sel;
      if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_valid <= 1'b1;
          rsp_id    <= job_q;
          rsp_data  <= (job_q == JOB_ENC) ? slv_out_1 : {18'b0, slv_out_2};
          busy      <= 1'b0;
          slv_work  <= JOB_HOLD;
        end
      end
    end
  end

endmodule

// File: tb/tb_solver_scheduler.sv
// Randomized scoreboard bench for solver_scheduler: a cycle-timeline reference model
// predicts grants, work codes and results; a separate monitor checks each response.
module tb_solver_scheduler;
  localparam int LAT_ENC = 3;
  localparam int LAT_DEC = 3;
  localparam int LAT_PW  = 2;
  localparam int HN      = 8192;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        enc_req = 1'b0, dec_req = 1'b0, pw_req = 1'b0;
  logic [59:0] enc_data = '0;
  logic [77:0] dec_data = '0;
  logic        enc_gnt, dec_gnt, pw_gnt;
  logic [59:0] slv_data_1;
  logic [77:0] slv_data_2;
  logic [1:0]  slv_work;
  logic [77:0] slv_out_1 = '0;
  logic [59:0] slv_out_2 = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [77:0] rsp_data;
  logic        busy;

  solver_scheduler #(.LAT_ENC(LAT_ENC), .LAT_DEC(LAT_DEC), .LAT_PW(LAT_PW)) dut (
    .Clk(Clk), .Rst(Rst),
    .enc_req(enc_req), .enc_data(enc_data), .enc_gnt(enc_gnt),
    .dec_req(dec_req), .dec_data(dec_data), .dec_gnt(dec_gnt),
    .pw_req(pw_req), .pw_gnt(pw_gnt),
    .slv_data_1(slv_data_1), .slv_data_2(slv_data_2), .slv_work(slv_work),
    .slv_out_1(slv_out_1), .slv_out_2(slv_out_2),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { int id; int due; } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;
  logic [77:0] hist1 [HN];
  logic [59:0] hist2 [HN];
  logic [2:0]  gnt_seen = '0;
  bit          force_ones = 0;

  function automatic int lat_of(int id);
    case (id)
      0:       return LAT_ENC;
      1:       return LAT_DEC;
      default: return LAT_PW;
    endcase
  endfunction

  function automatic logic [77:0] r78();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[77:0];
  endfunction

  task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: jobs are points on a cycle timeline (grant T, work T+1..T+1+LAT,
  // result at T+2+LAT, next grant allowed from T+2+LAT).
  int          m_last = 2, m_free = 0, act_id = 0, act_t = -100;
  bit          m_active = 0, started = 0;
  logic [59:0] m_d1 = '0;
  logic [77:0] m_d2 = '0;

  always @(negedge Clk) begin
    int n, pick, i;
    bit inwin;
    logic [2:0] reqv, g;
    #1;
    n = cyc;
    hist1[n % HN] = slv_out_1;
    hist2[n % HN] = slv_out_2;
    reqv = {pw_req, dec_req, enc_req};
    inwin = m_active && (n >= act_t + 1) && (n <= act_t + 1 + lat_of(act_id));
    if (started) begin
      chk("slv_work", 78'(slv_work), inwin ? 78'(act_id) : 78'd3);
      chk("busy", 78'(busy), 78'(inwin));
      chk("slv_data_1", 78'(slv_data_1), 78'(m_d1));
      chk("slv_data_2", slv_data_2, m_d2);
    end
    pick = -1;
    if (started && !Rst && n >= m_free)
      for (int k = 1; k <= 3; k++) begin
        i = (m_last + k) % 3;
        if (pick < 0 && reqv[i]) pick = i;
      end
    g = '0;
    if (pick >= 0) g[pick] = 1'b1;
    if (started) chk("gnt", 78'({pw_gnt, dec_gnt, enc_gnt}), 78'(g));
    if (Rst) begin
      m_last = 2; m_free = n + 1; m_active = 0;
      m_d1 = '0; m_d2 = '0;
      sbq.delete();
      started = 1;
    end else if (pick >= 0) begin
      m_last = pick; m_active = 1; act_id = pick; act_t = n;
      m_free = n + 2 + lat_of(pick);
      if (pick == 0) m_d1 = enc_data;
      if (pick == 1) m_d2 = dec_data;
      sbq.push_back('{pick, n + 2 + lat_of(pick)});
    end
    gnt_seen = g;
  end

  // Monitor: pops an expectation whenever the DUT presents a result.
  logic [1:0]  h_id = '0;
  logic [77:0] h_data = '0;
  bit          mon_rst_prev = 0, mstarted = 0;

  always @(negedge Clk) begin
    exp_t e;
    logic [77:0] ed;
    if (mon_rst_prev) begin h_id = '0; h_data = '0; end
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      e = sbq.pop_front();
      checks++; failures++;
      $display("FAIL rsp_timeout cycle=%0d actual=no_rsp_valid required=rsp_valid_at_%0d", cyc, e.due);
    end
    if (mstarted) begin
      if (rsp_valid === 1'b1) begin
        if (sbq.size() == 0 || sbq[0].due != cyc) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected cycle=%0d actual=rsp_valid=1 required=rsp_valid=0", cyc);
        end else begin
          e = sbq.pop_front();
          ed = (e.id == 0) ? hist1[(e.due - 1) % HN] : {18'b0, hist2[(e.due - 1) % HN]};
          chk("rsp_id", 78'(rsp_id), 78'(e.id));
          chk("rsp_data", rsp_data, ed);
          h_id = 2'(e.id); h_data = ed;
        end
      end else begin
        chk("rsp_valid", 78'(rsp_valid), 78'd0);
        chk("rsp_id_hold", 78'(rsp_id), 78'(h_id));
        chk("rsp_data_hold", rsp_data, h_data);
      end
    end
    mon_rst_prev = Rst;
    if (Rst) mstarted = 1;
  end

  task automatic step(input bit e, input bit d, input bit p, input bit r);
    @(posedge Clk);
    #1;
    Rst = r; enc_req = e; dec_req = d; pw_req = p;
    enc_data = r78()[59:0];
    dec_data = r78();
    slv_out_1 = r78();
    slv_out_2 = force_ones ? '1 : r78()[59:0];
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) step(0, 0, 0, 0);
  endtask

  initial begin
    bit ce, cd, cp, rr;
    // single enc after reset
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    idle(2);
    step(1, 0, 0, 0);
    idle(8);
    // all three held: enc, dec, pw, enc ...
    for (int j = 0; j < 22; j++) step(1, 1, 1, 0);
    idle(6);
    // pw with all-ones solver output
    force_ones = 1;
    step(0, 0, 1, 0);
    idle(6);
    force_ones = 0;
    // reset mid-job, then enc and dec pending
    step(0, 1, 0, 0);
    idle(2);
    step(1, 1, 0, 1);
    step(1, 1, 0, 0);
    for (int j = 0; j < 8; j++) step(0, 1, 0, 0);
    idle(4);
    // back-to-back dec, then a dec request dropped just before its grant
    for (int j = 0; j < 12; j++) step(0, 1, 0, 0);
    idle(6);
    step(1, 0, 0, 0);
    for (int j = 0; j < 3; j++) step(0, 1, 0, 0);
    idle(8);
    // random traffic with protocol-following requesters, occasional drops and resets
    ce = 0; cd = 0; cp = 0;
    for (int j = 0; j < 2500; j++) begin
      if (ce) ce = gnt_seen[0] ? ($urandom_range(2) == 0) : ($urandom_range(15) != 0);
      else    ce = ($urandom_range(2) == 0);
      if (cd) cd = gnt_seen[1] ? ($urandom_range(2) == 0) : ($urandom_range(15) != 0);
      else    cd = ($urandom_range(2) == 0);
      if (cp) cp = gnt_seen[2] ? ($urandom_range(2) == 0) : ($urandom_range(15) != 0);
      else    cp = ($urandom_range(2) == 0);
      rr = ($urandom_range(59) == 0);
      force_ones = ($urandom_range(7) == 0);
      step(ce, cd, cp, rr);
    end
    force_ones = 0;
    idle(24);
    @(negedge Clk); #2;
    chk("scoreboard_drained", 78'(sbq.size()), 78'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/solver_scheduler.md
SOLVER_SCHEDULER -- requirements
Module: solver_scheduler

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- LAT_ENC, 3, Solver cycles from work code 2'b00 applied to valid encrypted output.
- LAT_DEC, 3, same for work code 2'b01.
- LAT_PW, 2, same for work code 2'b10.
- Legal range 1..15 each.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- Clk, in, 1, single clock, rising edge.
- Rst, in, 1, synchronous, active-high reset.
- enc_req, in, 1, encrypt job request.
- enc_data, in, 60, plaintext.
- enc_gnt, out, 1, encrypt accept pulse.
- dec_req, in, 1, decrypt job request.
- dec_data, in, 78, ciphertext.
- dec_gnt, out, 1, decrypt accept pulse.
- pw_req, in, 1, password-generate job request.
- pw_gnt, out, 1, password accept pulse.
- slv_data_1, out, 60, to Solver data_1_80.
- slv_data_2, out, 78, to Solver data_2_96.
- slv_work, out, 2, to Solver work_2.
- slv_out_1, in, 78, from Solver output_1_96.
- slv_out_2, in, 60, from Solver output_2_80.
- rsp_valid, out, 1, result pulse.
- rsp_id, out, 2, job type: 0 enc, 1 dec, 2 pw.
- rsp_data, out, 78, result.
- busy, out, 1, job in flight.

Function
REQ-003 FSM SHALL have states IDLE, ISSUE, WAIT, DONE; all outputs SHALL be registered.
REQ-004 IDLE: if any req is high, the block SHALL grant exactly one requester.
- Grant is round-robin, starting after the last-granted type; order enc -> dec -> pw -> enc.
- The matching gnt is a one-cycle pulse in that cycle; then go to ISSUE.
- With no req, stay in IDLE.
REQ-005 On grant, the block SHALL latch inputs:
- enc_data into slv_data_1, or dec_data into slv_data_2.
- The other data register holds its value.
- pw latches no data.
REQ-006 Requesters SHALL hold req until gnt; a req dropped before gnt SHALL be neither served nor remembered.
REQ-007 ISSUE SHALL drive slv_work to the job code and load the 4-bit down-counter with the job's LAT, then go to WAIT.
REQ-008 WAIT SHALL hold slv_work and decrement the counter each cycle.
- When the counter reaches 1, sample slv_out_1 (enc) or slv_out_2 (dec, pw) and go to DONE.
REQ-009 Timing for a grant in cycle T SHALL be:
- slv_work = job code in cycles T+1 .. T+1+LAT.
- rsp_valid = 1 for exactly cycle T+2+LAT, with rsp_id set.
- rsp_data = the value sampled at the end of cycle T+1+LAT.
REQ-010 Width rule: 60-bit results SHALL be zero-extended into rsp_data[77:60]; enc results are passed through all 78 bits.
REQ-011 slv_work SHALL be 2'b11 (Solver hold) in IDLE and DONE.
REQ-012 DONE SHALL last one cycle and behave as IDLE: it may grant a new job in the same cycle that rsp_valid is high.
- Peak throughput is one job per LAT+2 cycles.
REQ-013 busy SHALL be 1 from the cycle after a grant through the cycle before rsp_valid.
REQ-014 rsp_id and rsp_data SHALL hold their last values when rsp_valid = 0.
REQ-015 Requests arriving while busy SHALL be ignored until IDLE/DONE; no queueing.

Reset
REQ-016 When Rst = 1 at a rising edge, the next state SHALL be IDLE, with:
- all gnt = 0, rsp_valid = 0, busy = 0;
- slv_work = 2'b11;
- slv_data_1, slv_data_2, rsp_data, rsp_id = 0;
- counter = 0;
- round-robin pointer set so enc has highest priority.
REQ-017 Rst during ISSUE or WAIT SHALL abandon the job with no rsp_valid pulse; Rst SHALL take priority over all requests.

Verification
REQ-018 Single enc: Rst released, enc_req = 1 with enc_data = 60'h0_ABCD in cycle 5.
- enc_gnt in cycle 5; slv_work = 00 in cycles 6-9.
- rsp_valid in cycle 10 with rsp_id = 0 and rsp_data = slv_out_1 value at cycle 9.
REQ-019 Three simultaneous reqs held high after reset:
- Grant order enc, dec, pw, enc.
- Grants at cycles T, T+5, T+10, T+14 (LAT 3, 3, 2, 3).
REQ-020 pw job with slv_out_2 = 60'hFFF_FFFF_FFFF_FFFF: rsp_data = 78'h000_0FFF_FFFF_FFFF_FFFF, rsp_id = 2.
REQ-021 Reset mid-job: Rst = 1 during WAIT.
- Next cycle: slv_work = 11, busy = 0, no rsp_valid.
- With dec_req and enc_req both pending afterwards, enc is granted first.
REQ-022 Back-to-back: dec_req held through a job's DONE cycle.
- rsp_valid and dec_gnt both high in that cycle.
- dec_req dropped one cycle before an expected grant is never granted.
